liteeth_sram_fifo_ctrl: RTL and testbench



---
 rtl/liteeth_sram_fifo_ctrl.sv | 111 +++++++++++
 tb/tb_liteeth_sram_fifo_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/liteeth_sram_fifo_ctrl.sv
// FIFO controller around a 1rw1r SRAM macro: writes go through rw0, the r0 port prefetches
// into a 2-entry output buffer so the pop side is first-word-fall-through at full rate.
module liteeth_sram_fifo_ctrl #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 128,
  parameter int unsigned AW    = 7
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             flush,

  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,

  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,

  output logic [AW+1:0]    level,

  output logic             rw0_ce_in,
  output logic             rw0_we_in,
  output logic [AW-1:0]    rw0_addr_in,
  output logic [WIDTH-1:0] rw0_wd_in,

  output logic             r0_ce_in,
  output logic [AW-1:0]    r0_addr_in,
  input  logic [WIDTH-1:0] r0_rd_out
);

  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [AW:0]      sram_cnt;
  logic             inflight_q, inflight_d;
  logic [1:0]       buf_cnt_q, buf_cnt_d;
  logic [WIDTH-1:0] buf_q [2];
  logic [WIDTH-1:0] buf_d [2];

  logic       clr;
  logic       push;
  logic       pop;
  logic [1:0] occ;

  assign clr      = sys_rst | flush;
  assign sram_cnt = wptr_q - rptr_q;

  assign in_ready = !clr && (sram_cnt != FullCnt);
  assign push     = in_valid && in_ready;

  assign out_valid = buf_cnt_q != 2'd0;
  assign out_data  = buf_q[0];
  assign pop       = out_valid && out_ready && !clr;

  assign rw0_ce_in   = push;
  assign rw0_we_in   = push;
  assign rw0_addr_in = wptr_q[AW-1:0];
  assign rw0_wd_in   = in_data;

  // Buffer slots committed once this cycle's pop and any in-flight capture settle (never > 2).
  assign occ = buf_cnt_q + {1'b0, inflight_q} - {1'b0, pop};

  assign r0_ce_in   = !clr && (sram_cnt != '0) && !occ[1];
  assign r0_addr_in = rptr_q[AW-1:0];

  assign level = {1'b0, sram_cnt} + {{(AW+1){1'b0}}, inflight_q} + {{AW{1'b0}}, buf_cnt_q};

  always_comb begin
    wptr_d     = wptr_q + {{AW{1'b0}}, push};
    rptr_d     = rptr_q + {{AW{1'b0}}, r0_ce_in};
    inflight_d = r0_ce_in;
    buf_cnt_d  = occ;
    buf_d[0]   = buf_q[0];
    buf_d[1]   = buf_q[1];
    if (pop) begin
      buf_d[0] = buf_q[1];
    end
    // With a capture pending, the landing slot is occ-1, i.e. occ[1] for occ in {1,2}.
    if (inflight_q) begin
      buf_d[occ[1]] = r0_rd_out;
    end
    if (clr) begin
      wptr_d     = '0;
      rptr_d     = '0;
      inflight_d = 1'b0;
      buf_cnt_d  = 2'd0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      inflight_q <= 1'b0;
      buf_cnt_q  <= 2'd0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      inflight_q <= inflight_d;
      buf_cnt_q  <= buf_cnt_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    buf_q[0] <= buf_d[0];
    buf_q[1] <= buf_d[1];
  end

endmodule

// File: tb/tb_liteeth_sram_fifo_ctrl.sv
// Bench for liteeth_sram_fifo_ctrl: behavioural SRAM plus a queue-based reference of the FIFO.
module tb_liteeth_sram_fifo_ctrl;

  localparam int WIDTH = 12;
  localparam int DEPTH = 128;
  localparam int AW    = 7;

  logic             sys_clk = 1'b0;
  logic             sys_rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [AW+1:0]    level;
  logic             rw0_ce_in;
  logic             rw0_we_in;
  logic [AW-1:0]    rw0_addr_in;
  logic [WIDTH-1:0] rw0_wd_in;
  logic             r0_ce_in;
  logic [AW-1:0]    r0_addr_in;
  logic [WIDTH-1:0] r0_rd_out;

  liteeth_sram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .level       (level),
    .rw0_ce_in   (rw0_ce_in),
    .rw0_we_in   (rw0_we_in),
    .rw0_addr_in (rw0_addr_in),
    .rw0_wd_in   (rw0_wd_in),
    .r0_ce_in    (r0_ce_in),
    .r0_addr_in  (r0_addr_in),
    .r0_rd_out   (r0_rd_out)
  );

  always #5 sys_clk = ~sys_clk;

  // Macro model: synchronous read; garbage on the read port whenever ce was low.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge sys_clk) begin
    if (rw0_ce_in && rw0_we_in) mem[rw0_addr_in] <= rw0_wd_in;
    if (r0_ce_in) r0_rd_out <= mem[r0_addr_in];
    else          r0_rd_out <= WIDTH'($urandom);
  end

  // Reference: contents in order, plus counts of writes/reads/pops since the last clear.
  logic [WIDTH-1:0] q[$];
  int wcnt, rcnt, popcnt;
  int n_err = 0;
  int n_checks = 0;
  logic f_clr, f_push, f_pop, f_rd;
  logic [WIDTH-1:0] d_smp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    @(negedge sys_clk);
    f_clr  = sys_rst || flush;
    f_push = in_valid && in_ready && !f_clr;
    f_pop  = out_valid && out_ready && !f_clr;
    f_rd   = r0_ce_in;
    d_smp  = in_data;
    chk("level", 32'(level), 32'(q.size()));
    if (f_clr) begin
      chk("in_ready_clr", 32'(in_ready), 32'd0);
      chk("r0_ce_clr", 32'(r0_ce_in), 32'd0);
    end else begin
      if (q.size() < DEPTH) chk("in_ready_room", 32'(in_ready), 32'd1);
      if (q.size() >= DEPTH + 2) chk("in_ready_full", 32'(in_ready), 32'd0);
    end
    chk("rw0_ce", 32'(rw0_ce_in), 32'(f_push));
    chk("rw0_we", 32'(rw0_we_in), 32'(f_push));
    if (f_push) begin
      chk("rw0_addr", 32'(rw0_addr_in), 32'(wcnt % DEPTH));
      chk("rw0_wd", 32'(rw0_wd_in), 32'(in_data));
    end
    if (q.size() == 0) chk("out_valid_empty", 32'(out_valid), 32'd0);
    if (f_pop && q.size() != 0) chk("out_data", 32'(out_data), 32'(q[0]));
    if (f_rd && !f_clr) begin
      chk("r0_addr", 32'(r0_addr_in), 32'(rcnt % DEPTH));
      chk("rd_after_write", 32'(rcnt < wcnt), 32'd1);
      chk("rd_buf_room", 32'((rcnt + 1 - popcnt - int'(f_pop)) <= 2), 32'd1);
    end
  endtask

  task automatic advance();
    @(posedge sys_clk);
    #1;
    if (f_clr) begin
      q.delete();
      wcnt = 0; rcnt = 0; popcnt = 0;
    end else begin
      if (f_pop) begin
        void'(q.pop_front());
        popcnt++;
      end
      if (f_push) begin
        q.push_back(d_smp);
        wcnt++;
      end
      if (f_rd) rcnt++;
    end
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 400 && q.size() != 0; k++) begin
      sample();
      advance();
    end
    out_ready = 1'b0;
    sample();
    chk("drained_level", 32'(level), 32'd0);
    chk("drained_model", 32'(q.size()), 32'd0);
    advance();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    sys_rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    wcnt = 0; rcnt = 0; popcnt = 0;
    repeat (2) @(posedge sys_clk);
    #1;
    sample();
    advance();
    sys_rst = 1'b0;

    // Reset then idle
    for (int i = 0; i < 10; i++) begin
      sample();
      chk("idle_in_ready", 32'(in_ready), 32'd1);
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      chk("idle_level", 32'(level), 32'd0);
      chk("idle_r0_ce", 32'(r0_ce_in), 32'd0);
      chk("idle_rw0_ce", 32'(rw0_ce_in), 32'd0);
      advance();
    end

    // Single word latency
    in_valid = 1'b1; in_data = 12'hABC;
    sample();
    chk("sw_rw0_we", 32'(rw0_we_in), 32'd1);
    chk("sw_rw0_addr", 32'(rw0_addr_in), 32'd0);
    advance();
    in_valid = 1'b0;
    sample();
    chk("sw_r0_ce", 32'(r0_ce_in), 32'd1);
    chk("sw_r0_addr", 32'(r0_addr_in), 32'd0);
    chk("sw_c1_valid", 32'(out_valid), 32'd0);
    advance();
    sample();
    chk("sw_c2_valid", 32'(out_valid), 32'd0);
    advance();
    out_ready = 1'b1;
    sample();
    chk("sw_c3_valid", 32'(out_valid), 32'd1);
    chk("sw_c3_data", 32'(out_data), 32'hABC);
    advance();
    out_ready = 1'b0;
    sample();
    chk("sw_level_after_pop", 32'(level), 32'd0);
    advance();

    // Fill to capacity
    for (int i = 0; i < DEPTH + 2; i++) begin
      in_valid = 1'b1; in_data = WIDTH'(i);
      sample();
      chk("fill_accept", 32'(in_ready), 32'd1);
      advance();
    end
    in_data = 12'hFFF;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("fill_refused", 32'(in_ready), 32'd0);
      chk("fill_level", 32'(level), 32'(DEPTH + 2));
      advance();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    sample();
    advance();
    out_ready = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 2 && !seen; k++) begin
      sample();
      seen = in_ready;
      advance();
    end
    chk("fill_reopen", 32'(seen), 32'd1);
    drain();

    // Streaming with wrap-around
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      in_data = WIDTH'($urandom);
      sample();
      if (i >= 3) chk("stream_no_bubble", 32'(out_valid), 32'd1);
      advance();
    end
    drain();

    // Random backpressure
    for (int i = 0; i < 5000; i++) begin
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      in_data   = WIDTH'($urandom);
      sample();
      advance();
    end
    drain();

    // Flush mid-operation with a read in flight
    out_ready = 1'b0;
    for (int i = 0; i < 41; i++) begin
      in_valid = 1'b1; in_data = WIDTH'($urandom);
      sample();
      advance();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    sample();
    chk("fl_issue", 32'(r0_ce_in), 32'd1);
    advance();
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 12'h555;
    sample();
    chk("fl_in_ready", 32'(in_ready), 32'd0);
    chk("fl_level_before", 32'(level), 32'd40);
    chk("fl_rw0_ce", 32'(rw0_ce_in), 32'd0);
    advance();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sample();
    chk("fl_level_after", 32'(level), 32'd0);
    chk("fl_valid_after", 32'(out_valid), 32'd0);
    advance();
    in_valid = 1'b1; in_data = 12'h123;
    sample();
    advance();
    in_valid = 1'b0;
    for (int c = 1; c < 3; c++) begin
      sample();
      chk("fl_lat_early", 32'(out_valid), 32'd0);
      advance();
    end
    out_ready = 1'b1;
    sample();
    chk("fl_lat_valid", 32'(out_valid), 32'd1);
    chk("fl_lat_data", 32'(out_data), 32'h123);
    advance();
    out_ready = 1'b0;
    sample();
    chk("fl_final_level", 32'(level), 32'd0);
    advance();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
